dm_bytectl: RTL and testbench
=============================

// Module: dm_bytectl
// PURPOSE
//   Parametrised data memory for the pipelined CPU: word/half/byte stores, sign/zero-extending loads.
//   Req/Ready handshake, configurable read latency, misalignment/range exception, multi-cycle clear sweep.
//   Sits in the MEM stage; drives the store log line and returns extended load data to WB.
// PARAMETERS
//   DEPTH_WORDS  3072          number of 32-bit words
//   BASE_ADDR    32'h0000_0000 byte address mapped to word 0
//   RD_LAT       1             response latency in cycles after accept; legal values 1 or 2
// PORTS
//   Clk      in   1   clock, rising edge
//   Reset_n  in   1   asynchronous, active-low reset
//   Req      in   1   access request valid
//   Ready    out  1   request can be accepted this cycle; accept = Req & Ready
//   DMWr     in   1   1 = store, 0 = load
//   Op       in   3   size/sign: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
//   A        in   32  byte address
//   WD       in   32  store data, right-aligned for sub-word stores
//   PC       in   32  instruction address, used for the store log only
//   ClrReq   in   1   synchronous soft clear; sampled only in IDLE
//   RValid   out  1   response valid: one pulse per accepted request, loads and stores
//   RD       out  32  extended load data; 0 for stores and exceptions
//   Excp     out  1   qualifies RValid: the access was suppressed
// BEHAVIOUR
//   Reset_n low, immediate: FSM=CLEAR, clear pointer=0, response pipeline flushed.
//     Ready=0, RValid=0, RD=0, Excp=0.
//   CLEAR state:
//     - writes 0 to word[ptr], one word per cycle, ptr++.
//     - after ptr==DEPTH_WORDS-1 is written, moves to IDLE; Ready=1 from the next cycle.
//     - sweep takes DEPTH_WORDS cycles; Reset_n asserted mid-sweep restarts it at 0.
//   IDLE, ClrReq=1: enters CLEAR.
//     - Ready drops the same cycle (combinational from ClrReq); no accept in that cycle.
//     - responses already in the pipeline still complete.
//   Ready=0: Req is ignored and produces no response; the requester holds Req.
//   Legality checks, evaluated at accept:
//     - off = A - BASE_ADDR must be < DEPTH_WORDS*4 (unsigned, 32-bit wrap).
//     - word accesses need A[1:0]==0; half accesses need A[0]==0.
//     - Op values 101..111 are illegal.
//   Illegal access: no array write. Response after RD_LAT has RValid=1, Excp=1, RD=0.
//   Legal store: lanes written at the accept edge.
//     - word: all 4 bytes.
//     - half: WD[15:0] into bytes {A[1],1'b0}+1 and {A[1],1'b0}.
//     - byte: WD[7:0] into byte A[1:0].
//     - simulation-only log: $display("@%h: *%h <= %h", PC, {A[31:2],2'b00}, merged_word).
//     - response: RValid=1, Excp=0, RD=0.
//   Legal load: word read at the accept edge, so a store accepted in an earlier cycle is visible.
//     - select lane by A[1:0], then sign- or zero-extend per Op.
//     - RD_LAT=1: RD/RValid registered 1 cycle after accept.
//     - RD_LAT=2: raw word registered, extension registered; RValid 2 cycles after accept.
//     - a store accepted after a load never alters that load's data.
//   Throughput: one accept per cycle in IDLE. Response order equals accept order.
//   Outputs held 0 whenever RValid=0.
// STRUCTURE
//   Package dm_pkg:
//     - Op encodings (OP_W, OP_HS, OP_HU, OP_BS, OP_BU).
//     - FSM enum {CLEAR, IDLE}.
//     - localparam RD_LAT_MAX=2.
//   Sub-module dm_lane_unit (combinational): store byte-merge mask/data and load lane-select/extend.
//   Top: array, clear FSM/counter, legality check, RD_LAT response shift register.
// TESTING
//   1 Reset_n low 3 cyc, release -> Ready=0 exactly DEPTH_WORDS cyc, then 1; load any word -> RD=0.
//   2 sw 0x11223344 @0x10; lb @0x13 -> RD=0x00000011; lb @0x10 with 0x80 stored -> RD=0xFFFFFF80;
//     lbu @0x10 -> RD=0x00000080.
//   3 sh 0xBEEF @0x22 over word 0 -> word 0x20 = 0xBEEF0000; lh @0x22 -> RD=0xFFFFBEEF;
//     lhu @0x22 -> 0x0000BEEF.
//   4 lw @0x5, sh @0x3, lw @DEPTH_WORDS*4, Op=110 -> each gives RValid=1, Excp=1, RD=0; memory unchanged.
//   5 back-to-back sw 0xA5A5A5A5 @0x40 then lw @0x40, RD_LAT=1 and RD_LAT=2
//     -> RD=0xA5A5A5A5 at accept+RD_LAT; one RValid per accept, in order.
//   6 Reset_n asserted mid-sweep and mid-load -> RValid drops immediately, no stale response, sweep restarts;
//     ClrReq in IDLE -> Ready=0 DEPTH_WORDS cyc, memory all 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory.
// Op size/sign codes, FSM states and the alignment rule used at accept.
package dm_pkg;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HS = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_BS = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  localparam int unsigned RD_LAT_MAX = 2;

  typedef enum logic {CLEAR, IDLE} dm_state_e;

  // True when op is a defined encoding and the byte offset suits its size.
  function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      OP_W:         return lane == 2'b00;
      OP_HS, OP_HU: return !lane[0];
      OP_BS, OP_BU: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane logic: store merge into the old word and load lane
// select with sign/zero extension.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_old,
  input  logic [31:0] st_wd,
  output logic [31:0] st_word,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] shifted;

  always_comb begin
    be      = 4'b0000;
    wdata   = st_wd;
    st_word = st_old;
    case (st_op)
      OP_W: be = 4'b1111;
      OP_HS, OP_HU: begin
        be    = st_lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_wd[15:0]}};
      end
      OP_BS, OP_BU: begin
        be    = 4'b0001 << st_lane;
        wdata = {4{st_wd[7:0]}};
      end
      default: be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (be[i]) st_word[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Legal word loads always have lane 0, so the shift is a no-op for them.
  assign shifted = ld_word >> {ld_lane, 3'b000};

  always_comb begin
    ld_data = '0;
    case (ld_op)
      OP_W:  ld_data = shifted;
      OP_HS: ld_data = {{16{shifted[15]}}, shifted[15:0]};
      OP_HU: ld_data = {16'h0000, shifted[15:0]};
      OP_BS: ld_data = {{24{shifted[7]}}, shifted[7:0]};
      OP_BU: ld_data = {24'h000000, shifted[7:0]};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dm_bytectl.sv
// Data memory for the MEM stage: sub-word stores, extending loads, legality
// exceptions, clear sweep after reset or ClrReq, and an RD_LAT-deep response pipe.
module dm_bytectl
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req,
  output logic        Ready,
  input  logic        DMWr,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  input  logic        ClrReq,
  output logic        RValid,
  output logic [31:0] RD,
  output logic        Excp
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [31:0] mem [DEPTH_WORDS];

  dm_state_e   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  logic          accept, legal, st_en, ld_en;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word, st_word, ld_data;
  logic [2:0]    ld_op;
  logic [1:0]    ld_lane;
  logic [31:0]   ld_word;
  logic          rvalid_q, excp_q;
  logic [31:0]   rd_q;

  assign Ready   = (state_q == IDLE) && !ClrReq;
  assign accept  = Req && Ready;
  assign off     = A - BASE_ADDR;
  assign idx     = off[AW+1:2];
  assign legal   = (off < SPAN) && op_aligned(Op, A[1:0]);
  assign st_en   = accept && legal && DMWr;
  assign ld_en   = accept && legal && !DMWr;
  assign rd_word = mem[idx];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      IDLE: begin
        if (ClrReq) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // No accepts happen while clearing, so the sweep owns the write port then.
  always_ff @(posedge Clk) begin
    if (state_q == CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (st_en) begin
      mem[idx] <= st_word;
    end
  end

  dm_lane_unit u_lane (
    .st_op   (Op),
    .st_lane (A[1:0]),
    .st_old  (rd_word),
    .st_wd   (WD),
    .st_word (st_word),
    .ld_op   (ld_op),
    .ld_lane (ld_lane),
    .ld_word (ld_word),
    .ld_data (ld_data)
  );

  if (RD_LAT == 1) begin : g_lat1
    assign ld_op   = Op;
    assign ld_lane = A[1:0];
    assign ld_word = rd_word;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        rvalid_q <= 1'b0;
        excp_q   <= 1'b0;
        rd_q     <= '0;
      end else begin
        rvalid_q <= accept;
        excp_q   <= accept && !legal;
        rd_q     <= ld_en ? ld_data : '0;
      end
    end
  end else begin : g_lat2
    logic        v1_q, ex1_q, ld1_q;
    logic [2:0]  op1_q;
    logic [1:0]  lane1_q;
    logic [31:0] word1_q;

    assign ld_op   = op1_q;
    assign ld_lane = lane1_q;
    assign ld_word = word1_q;

    // Raw word captured at accept; extension happens in the second stage.
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        v1_q     <= 1'b0;
        ex1_q    <= 1'b0;
        ld1_q    <= 1'b0;
        op1_q    <= '0;
        lane1_q  <= '0;
        word1_q  <= '0;
        rvalid_q <= 1'b0;
        excp_q   <= 1'b0;
        rd_q     <= '0;
      end else begin
        v1_q     <= accept;
        ex1_q    <= accept && !legal;
        ld1_q    <= ld_en;
        op1_q    <= Op;
        lane1_q  <= A[1:0];
        word1_q  <= ld_en ? rd_word : '0;
        rvalid_q <= v1_q;
        excp_q   <= ex1_q;
        rd_q     <= ld1_q ? ld_data : '0;
      end
    end
  end

  assign RValid = rvalid_q;
  assign Excp   = excp_q;
  assign RD     = rd_q;

`ifndef SYNTHESIS
  always @(posedge Clk) begin
    if (st_en) $display("@%h: *%h <= %h", PC, {A[31:2], 2'b00}, st_word);
  end
`endif

endmodule

// File: tb/tb_dm_bytectl.sv
// Drives RD_LAT=1 and RD_LAT=2 instances with shared stimulus and compares
// both against a byte-addressed reference model with per-instance response queues.
module tb_dm_bytectl;
  import dm_pkg::*;

  localparam int unsigned DEPTH = 3072;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Req = 1'b0, DMWr = 1'b0, ClrReq = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] A = '0, WD = '0, PC = '0;
  logic        ready1, ready2, rvalid1, rvalid2, excp1, excp2;
  logic [31:0] rd1, rd2;

  always #5 Clk = ~Clk;

  dm_bytectl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .RD_LAT(1)) u_dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Ready(ready1), .DMWr(DMWr), .Op(Op),
    .A(A), .WD(WD), .PC(PC), .ClrReq(ClrReq), .RValid(rvalid1), .RD(rd1), .Excp(excp1)
  );

  dm_bytectl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .RD_LAT(2)) u_dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Ready(ready2), .DMWr(DMWr), .Op(Op),
    .A(A), .WD(WD), .PC(PC), .ClrReq(ClrReq), .RValid(rvalid2), .RD(rd2), .Excp(excp2)
  );

  typedef struct {
    int          due;
    logic        excp;
    logic [31:0] rd;
  } resp_t;

  resp_t       q1[$];
  resp_t       q2[$];
  logic [31:0] ref_mem [DEPTH];
  int          clear_left;
  int          cyc;
  int          nvec;
  int          nerr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_legal(input logic [2:0] op, input logic [31:0] a);
    if (a >= 32'(DEPTH * 4)) return 1'b0;
    if (op > 3'd4) return 1'b0;
    if (op == 3'd0) return (a % 4) == 0;
    if (op == 3'd1 || op == 3'd2) return (a % 2) == 0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    v = ref_mem[a / 4] >> ((a % 4) * 8);
    case (op)
      3'd0: return v;
      3'd1: begin v = v & 32'hFFFF; return (v >= 32'h8000) ? v - 32'h10000 : v; end
      3'd2: return v & 32'hFFFF;
      3'd3: begin v = v & 32'hFF; return (v >= 32'h80) ? v - 32'h100 : v; end
      default: return v & 32'hFF;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int n;
    int b;
    int w;
    n = (op == 3'd0) ? 4 : ((op <= 3'd2) ? 2 : 1);
    b = int'(a % 4);
    w = int'(a / 4);
    for (int i = 0; i < n; i++) ref_mem[w][8*(b+i) +: 8] = wd[8*i +: 8];
  endtask

  task automatic model_wipe();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic resp_check(input int which, input logic v, input logic ex, input logic [31:0] d);
    resp_t e;
    logic  hit;
    hit = 1'b0;
    if (which == 1) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin hit = 1'b1; e = q1.pop_front(); end
    end else begin
      if (q2.size() > 0 && q2[0].due == cyc) begin hit = 1'b1; e = q2.pop_front(); end
    end
    if (hit) begin
      check($sformatf("rvalid%0d", which), 32'(v), 32'd1);
      check($sformatf("excp%0d", which), 32'(ex), 32'(e.excp));
      check($sformatf("rd%0d", which), d, e.rd);
    end else begin
      check($sformatf("rvalid%0d_idle", which), 32'(v), 32'd0);
      check($sformatf("excp%0d_idle", which), 32'(ex), 32'd0);
      check($sformatf("rd%0d_idle", which), d, 32'd0);
    end
  endtask

  // One clock: apply inputs, check outputs mid-cycle, then advance the model.
  task automatic cycle_step(input logic req, input logic wr, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] wd, input logic clr);
    logic  ready_m;
    logic  lg;
    resp_t r;
    Req = req; DMWr = wr; Op = op; A = a; WD = wd; ClrReq = clr;
    PC = 32'h0000_1000 + 32'(cyc) * 4;
    @(negedge Clk);
    ready_m = (clear_left == 0) && !clr;
    check("ready1", 32'(ready1), 32'(ready_m));
    check("ready2", 32'(ready2), 32'(ready_m));
    resp_check(1, rvalid1, excp1, rd1);
    resp_check(2, rvalid2, excp2, rd2);
    if (clear_left > 0) begin
      clear_left--;
    end else if (clr) begin
      clear_left = DEPTH;
      model_wipe();
    end else if (req) begin
      lg     = model_legal(op, a);
      r.excp = !lg;
      r.rd   = '0;
      if (lg && wr) model_store(op, a, wd);
      if (lg && !wr) r.rd = model_load(op, a);
      r.due = cyc + 1; q1.push_back(r);
      r.due = cyc + 2; q2.push_back(r);
    end
    @(posedge Clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int hold);
    Req = 1'b0; ClrReq = 1'b0;
    Reset_n = 1'b0;
    #1;
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_rvalid2", 32'(rvalid2), 32'd0);
    check("rst_excp1", 32'(excp1), 32'd0);
    check("rst_excp2", 32'(excp2), 32'd0);
    check("rst_rd1", rd1, 32'd0);
    check("rst_rd2", rd2, 32'd0);
    check("rst_ready1", 32'(ready1), 32'd0);
    check("rst_ready2", 32'(ready2), 32'd0);
    clear_left = DEPTH;
    q1.delete();
    q2.delete();
    model_wipe();
    repeat (hold) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_step(1'b0, 1'b0, OP_W, '0, '0, 1'b0);
  endtask

  // Runs out any clear sweep while pressing Req, which must be ignored.
  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && clear_left > 0; i++)
      cycle_step(1'($urandom_range(1, 0)), 1'b0, OP_W, 32'($urandom_range(255, 0)) & 32'hFC,
                 '0, 1'b0);
  endtask

  task automatic st(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    cycle_step(1'b1, 1'b1, op, a, wd, 1'b0);
  endtask

  task automatic ld(input logic [2:0] op, input logic [31:0] a);
    cycle_step(1'b1, 1'b0, op, a, '0, 1'b0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    nvec = 0; nerr = 0; cyc = 0; clear_left = DEPTH;
    #2;
    do_reset(3);
    drain();
    for (int i = 0; i < 6; i++) ld(OP_W, 32'($urandom_range(DEPTH - 1, 0)) * 4);

    st(OP_W, 32'h10, 32'h1122_3344);
    ld(OP_BS, 32'h13);
    st(OP_BS, 32'h10, 32'h0000_0080);
    ld(OP_BS, 32'h10);
    ld(OP_BU, 32'h10);

    st(OP_HS, 32'h22, 32'h0000_BEEF);
    ld(OP_W, 32'h20);
    ld(OP_HS, 32'h22);
    ld(OP_HU, 32'h22);

    st(OP_W, 32'h0, 32'hCAFE_F00D);
    ld(OP_W, 32'h5);
    st(OP_HS, 32'h3, 32'h0000_DEAD);
    ld(OP_W, 32'(DEPTH * 4));
    ld(3'b110, 32'h0);
    st(3'b111, 32'h10, 32'hFFFF_FFFF);
    st(OP_W, 32'hFFFF_FFFC, 32'h1234_5678);
    ld(OP_W, 32'h0);
    ld(OP_W, 32'h10);
    ld(OP_W, 32'(DEPTH * 4 - 4));

    st(OP_W, 32'h40, 32'hA5A5_A5A5);
    ld(OP_W, 32'h40);
    st(OP_BU, 32'h40, 32'h0000_0011);
    idle(3);

    // Reset with a load in flight, then again part-way through the sweep.
    st(OP_W, 32'h80, 32'h7777_8888);
    ld(OP_W, 32'h80);
    do_reset(2);
    idle(40);
    do_reset(3);
    drain();
    ld(OP_W, 32'h80);

    st(OP_W, 32'h44, 32'h0BAD_BEEF);
    st(OP_HU, 32'h102, 32'h0000_9999);
    ld(OP_W, 32'h44);
    cycle_step(1'b1, 1'b0, OP_W, 32'h44, '0, 1'b1);
    drain();
    ld(OP_W, 32'h44);
    ld(OP_W, 32'h100);

    for (int i = 0; i < 1500; i++) begin
      rop = ($urandom_range(9, 0) == 0) ? 3'(5 + $urandom_range(2, 0)) : 3'($urandom_range(4, 0));
      case ($urandom_range(15, 0))
        0:       ra = $urandom;
        1:       ra = 32'(DEPTH * 4 - 4) + 32'($urandom_range(7, 0));
        default: ra = 32'($urandom_range(255, 0));
      endcase
      cycle_step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), rop, ra, $urandom,
                 1'($urandom_range(999, 0) == 0));
      if (clear_left > 0) drain();
    end
    idle(4);
    check("pending1", 32'(q1.size()), 32'd0);
    check("pending2", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
